// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the datapath control sequencer:
// opcodes, FSM states, instruction classes and the control bundle.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_JR   = 5'b10101;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_ADD = 5'b00011;

  typedef enum logic [3:0] {
    S_WAIT,
    S_F0,
    S_F1,
    S_F2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_T7,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    C_LD,
    C_LDI,
    C_ST,
    C_IMM,
    C_UN,
    C_BR,
    C_JAL,
    C_JR,
    C_NOP,
    C_HALT
  } iclass_t;

  typedef struct packed {
    logic       pc_en;
    logic       pc_inc;
    logic       ir_en;
    logic       y_en;
    logic       z_en;
    logic       mar_en;
    logic       mdr_en;
    logic       r_en;
    logic       con_en;
    logic       r15_en;
    logic       rd;
    logic       wr;
    logic       gra;
    logic       grb;
    logic       ba_sel;
    logic       pc_sel;
    logic       zlo_sel;
    logic       mdr_sel;
    logic       c_sel;
    logic       r_sel;
    logic [4:0] alu;
    logic       halted;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode classifier.
// Unknown opcodes map to the nop class with legal low.
module instr_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    iclass,
  output logic       legal
);

  always_comb begin
    iclass = C_NOP;
    legal  = 1'b1;
    case (opcode)
      OP_LD:   iclass = C_LD;
      OP_LDI:  iclass = C_LDI;
      OP_ST:   iclass = C_ST;
      OP_ADDI,
      OP_ANDI,
      OP_ORI:  iclass = C_IMM;
      OP_NEG,
      OP_NOT:  iclass = C_UN;
      OP_BR:   iclass = C_BR;
      OP_JAL:  iclass = C_JAL;
      OP_JR:   iclass = C_JR;
      OP_NOP:  iclass = C_NOP;
      OP_HALT: iclass = C_HALT;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute FSM driving the datapath control pins.
// Moore outputs, forced low while reset_n is asserted.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned RESET_PC_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] IR_Data,
  input  logic        con_output,
  output logic        PC_enable,
  output logic        PC_increment_enable,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Z_enable,
  output logic        MAR_enable,
  output logic        MDR_enable,
  output logic        r_enable,
  output logic        con_enable,
  output logic        manual_R15_enable,
  output logic        read,
  output logic        write,
  output logic        Gra,
  output logic        Grb,
  output logic        ba_select,
  output logic        PC_select,
  output logic        Z_LO_select,
  output logic        MDR_select,
  output logic        c_select,
  output logic        r_select,
  output logic [4:0]  alu_instruction,
  output logic        halted,
  output logic        illegal
);

  localparam int CW =
    (RESET_PC_WAIT > 1) ? $clog2(RESET_PC_WAIT + 1) : 1;
  localparam state_t RST_S =
    (RESET_PC_WAIT == 0) ? S_F0 : S_WAIT;
  localparam logic [CW-1:0] WAIT_LAST =
    CW'(RESET_PC_WAIT - 1);

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt;
  iclass_t       iclass;
  logic          legal;
  logic [4:0]    opcode;
  ctrl_t         c, o;

  assign opcode = IR_Data[31:27];

  instr_decoder u_dec (
    .opcode (opcode),
    .iclass (iclass),
    .legal  (legal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RST_S;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= (state == S_WAIT) ?
                  wait_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_WAIT:
        if (wait_cnt == WAIT_LAST) state_nx = S_F0;
      S_F0: state_nx = S_F1;
      S_F1: state_nx = S_F2;
      S_F2: state_nx = S_T3;
      S_T3:
        case (iclass)
          C_JR, C_NOP: state_nx = S_F0;
          C_HALT:      state_nx = S_HALT;
          default:     state_nx = S_T4;
        endcase
      S_T4:
        case (iclass)
          C_UN, C_JAL: state_nx = S_F0;
          default:     state_nx = S_T5;
        endcase
      S_T5:
        case (iclass)
          C_LDI, C_IMM: state_nx = S_F0;
          default:      state_nx = S_T6;
        endcase
      S_T6:
        state_nx = (iclass == C_BR) ? S_F0 : S_T7;
      S_T7: state_nx = S_F0;
      S_HALT: state_nx = S_HALT;
      default: state_nx = RST_S;
    endcase
  end

  always_comb begin
    c = '0;
    unique case (state)
      S_F0: begin
        c.pc_sel = 1'b1;
        c.mar_en = 1'b1;
      end
      S_F1: begin
        c.pc_inc = 1'b1;
        c.rd     = 1'b1;
        c.mdr_en = 1'b1;
      end
      S_F2: begin
        c.mdr_sel = 1'b1;
        c.ir_en   = 1'b1;
      end
      S_T3: begin
        c.illegal = ~legal;
        case (iclass)
          C_LD, C_LDI, C_ST: begin
            c.grb    = 1'b1;
            c.ba_sel = 1'b1;
            c.y_en   = 1'b1;
          end
          C_IMM: begin
            c.grb   = 1'b1;
            c.r_sel = 1'b1;
            c.y_en  = 1'b1;
          end
          C_UN: begin
            c.grb   = 1'b1;
            c.r_sel = 1'b1;
            c.z_en  = 1'b1;
            c.alu   = opcode;
          end
          C_BR: begin
            c.gra    = 1'b1;
            c.r_sel  = 1'b1;
            c.con_en = 1'b1;
          end
          C_JAL: begin
            c.r15_en = 1'b1;
            c.pc_sel = 1'b1;
          end
          C_JR: begin
            c.gra   = 1'b1;
            c.r_sel = 1'b1;
            c.pc_en = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4:
        case (iclass)
          C_LD, C_LDI, C_ST, C_IMM: begin
            c.c_sel = 1'b1;
            c.z_en  = 1'b1;
            c.alu   = opcode;
          end
          C_UN: begin
            c.zlo_sel = 1'b1;
            c.gra     = 1'b1;
            c.r_en    = 1'b1;
          end
          C_BR: begin
            c.pc_sel = 1'b1;
            c.y_en   = 1'b1;
          end
          C_JAL: begin
            c.gra   = 1'b1;
            c.r_sel = 1'b1;
            c.pc_en = 1'b1;
          end
          default: ;
        endcase
      S_T5:
        case (iclass)
          C_LDI, C_IMM: begin
            c.zlo_sel = 1'b1;
            c.gra     = 1'b1;
            c.r_en    = 1'b1;
          end
          C_LD, C_ST: begin
            c.zlo_sel = 1'b1;
            c.mar_en  = 1'b1;
          end
          C_BR: begin
            c.c_sel = 1'b1;
            c.z_en  = 1'b1;
            c.alu   = ALU_ADD;
          end
          default: ;
        endcase
      S_T6:
        case (iclass)
          C_LD: begin
            c.rd     = 1'b1;
            c.mdr_en = 1'b1;
          end
          C_ST: begin
            c.gra    = 1'b1;
            c.r_sel  = 1'b1;
            c.mdr_en = 1'b1;
          end
          C_BR: begin
            c.zlo_sel = con_output;
            c.pc_en   = con_output;
          end
          default: ;
        endcase
      S_T7:
        case (iclass)
          C_LD: begin
            c.mdr_sel = 1'b1;
            c.gra     = 1'b1;
            c.r_en    = 1'b1;
          end
          C_ST: c.wr = 1'b1;
          default: ;
        endcase
      S_HALT: c.halted = 1'b1;
      default: ;
    endcase
  end

  // Reset must silence the pins without waiting for an edge.
  always_comb o = reset_n ? c : '0;

  assign PC_enable           = o.pc_en;
  assign PC_increment_enable = o.pc_inc;
  assign IR_enable           = o.ir_en;
  assign Y_enable            = o.y_en;
  assign Z_enable            = o.z_en;
  assign MAR_enable          = o.mar_en;
  assign MDR_enable          = o.mdr_en;
  assign r_enable            = o.r_en;
  assign con_enable          = o.con_en;
  assign manual_R15_enable   = o.r15_en;
  assign read                = o.rd;
  assign write               = o.wr;
  assign Gra                 = o.gra;
  assign Grb                 = o.grb;
  assign ba_select           = o.ba_sel;
  assign PC_select           = o.pc_sel;
  assign Z_LO_select         = o.zlo_sel;
  assign MDR_select          = o.mdr_sel;
  assign c_select            = o.c_sel;
  assign r_select            = o.r_sel;
  assign alu_instruction     = o.alu;
  assign halted              = o.halted;
  assign illegal             = o.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-cycle
// expected control words queued from a reference model.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] IR_Data;
  logic        con_output;
  logic PC_enable, PC_increment_enable, IR_enable;
  logic Y_enable, Z_enable, MAR_enable, MDR_enable;
  logic r_enable, con_enable, manual_R15_enable;
  logic read, write, Gra, Grb, ba_select;
  logic PC_select, Z_LO_select, MDR_select;
  logic c_select, r_select, halted, illegal;
  logic [4:0] alu_instruction;

  control_sequencer dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .IR_Data             (IR_Data),
    .con_output          (con_output),
    .PC_enable           (PC_enable),
    .PC_increment_enable (PC_increment_enable),
    .IR_enable           (IR_enable),
    .Y_enable            (Y_enable),
    .Z_enable            (Z_enable),
    .MAR_enable          (MAR_enable),
    .MDR_enable          (MDR_enable),
    .r_enable            (r_enable),
    .con_enable          (con_enable),
    .manual_R15_enable   (manual_R15_enable),
    .read                (read),
    .write               (write),
    .Gra                 (Gra),
    .Grb                 (Grb),
    .ba_select           (ba_select),
    .PC_select           (PC_select),
    .Z_LO_select         (Z_LO_select),
    .MDR_select          (MDR_select),
    .c_select            (c_select),
    .r_select            (r_select),
    .alu_instruction     (alu_instruction),
    .halted              (halted),
    .illegal             (illegal)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] PCE = 32'h1 << 5;
  localparam logic [31:0] PCI = 32'h1 << 6;
  localparam logic [31:0] IRE = 32'h1 << 7;
  localparam logic [31:0] YE  = 32'h1 << 8;
  localparam logic [31:0] ZE  = 32'h1 << 9;
  localparam logic [31:0] MAR = 32'h1 << 10;
  localparam logic [31:0] MDR = 32'h1 << 11;
  localparam logic [31:0] RE  = 32'h1 << 12;
  localparam logic [31:0] CON = 32'h1 << 13;
  localparam logic [31:0] R15 = 32'h1 << 14;
  localparam logic [31:0] RD  = 32'h1 << 15;
  localparam logic [31:0] WR  = 32'h1 << 16;
  localparam logic [31:0] GRA = 32'h1 << 17;
  localparam logic [31:0] GRB = 32'h1 << 18;
  localparam logic [31:0] BA  = 32'h1 << 19;
  localparam logic [31:0] PCS = 32'h1 << 20;
  localparam logic [31:0] ZLO = 32'h1 << 21;
  localparam logic [31:0] MDS = 32'h1 << 22;
  localparam logic [31:0] CS  = 32'h1 << 23;
  localparam logic [31:0] RS  = 32'h1 << 24;
  localparam logic [31:0] HLT = 32'h1 << 25;
  localparam logic [31:0] ILL = 32'h1 << 26;

  logic [31:0] obs;
  assign obs = {5'b0, illegal, halted, r_select, c_select,
                MDR_select, Z_LO_select, PC_select, ba_select,
                Grb, Gra, write, read, manual_R15_enable,
                con_enable, r_enable, MDR_enable, MAR_enable,
                Z_enable, Y_enable, IR_enable,
                PC_increment_enable, PC_enable, alu_instruction};

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];
  string       tag_q[$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    sb_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  // Reference model of one instruction, F0 through its last T-state.
  task automatic model(input logic [31:0] ir, input logic con,
                       input string nm);
    logic [4:0]  op;
    logic [31:0] a;
    op = ir[31:27];
    a  = {27'b0, op};
    push({nm, ".F0"}, PCS | MAR);
    push({nm, ".F1"}, PCI | RD | MDR);
    push({nm, ".F2"}, MDS | IRE);
    case (op)
      5'b00001, 5'b01100, 5'b01101, 5'b01110: begin
        push({nm, ".T3"}, (op == 5'b00001) ?
             (GRB | BA | YE) : (GRB | RS | YE));
        push({nm, ".T4"}, CS | ZE | a);
        push({nm, ".T5"}, ZLO | GRA | RE);
      end
      5'b00000, 5'b00010: begin
        push({nm, ".T3"}, GRB | BA | YE);
        push({nm, ".T4"}, CS | ZE | a);
        push({nm, ".T5"}, ZLO | MAR);
        if (op == 5'b00000) begin
          push({nm, ".T6"}, RD | MDR);
          push({nm, ".T7"}, MDS | GRA | RE);
        end else begin
          push({nm, ".T6"}, GRA | RS | MDR);
          push({nm, ".T7"}, WR);
        end
      end
      5'b10001, 5'b10010: begin
        push({nm, ".T3"}, GRB | RS | ZE | a);
        push({nm, ".T4"}, ZLO | GRA | RE);
      end
      5'b10011: begin
        push({nm, ".T3"}, GRA | RS | CON);
        push({nm, ".T4"}, PCS | YE);
        push({nm, ".T5"}, CS | ZE | 32'd3);
        push({nm, ".T6"}, con ? (ZLO | PCE) : 32'h0);
      end
      5'b10100: begin
        push({nm, ".T3"}, R15 | PCS);
        push({nm, ".T4"}, GRA | RS | PCE);
      end
      5'b10101: push({nm, ".T3"}, GRA | RS | PCE);
      5'b11010: push({nm, ".T3"}, 32'h0);
      5'b11011: begin
        push({nm, ".T3"}, 32'h0);
        for (int i = 0; i < 20; i++) push({nm, ".HALT"}, HLT);
      end
      default: push({nm, ".T3"}, ILL);
    endcase
  endtask

  // Pop and compare n entries, one per clock at the falling edge.
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'h1, 32'h0);
      end else begin
        chk(tag_q.pop_front(), obs, sb_q.pop_front());
      end
    end
  endtask

  // IR is changed during F0, before the DUT can decode it.
  task automatic run(input logic [31:0] ir, input logic con,
                     input string nm);
    model(ir, con, nm);
    drain(1);
    IR_Data    = ir;
    con_output = con;
    drain(sb_q.size());
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk({nm, ".async_zero"}, obs, 32'h0);
    sb_q.delete();
    tag_q.delete();
    repeat (2) @(posedge clk);
    #1 chk({nm, ".held_zero"}, obs, 32'h0);
    @(posedge clk);
    #2 reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    IR_Data    = 32'h0;
    con_output = 1'b0;
    #1 chk("reset.zero", obs, 32'h0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    run(32'h09000065, 1'b0, "ldi");
    run(32'hA1000000, 1'b0, "jal");
    run(32'h99800005, 1'b1, "br_taken");
    run(32'h99800005, 1'b0, "br_not");
    run(32'h18000000, 1'b0, "illegal");
    run(32'h88800000, 1'b0, "neg");
    run(32'h90800000, 1'b0, "not");
    run(32'hA9000000, 1'b0, "jr");
    run(32'hD0000000, 1'b0, "nop");
    run(32'h61000007, 1'b0, "addi");
    run(32'h71000007, 1'b0, "ori");
    run(32'h11000010, 1'b0, "st");
    run(32'h01000010, 1'b0, "ld");

    // Abort a ld at T5 and check recovery straight into F0.
    model(32'h01000010, 1'b0, "ld_abort");
    drain(1);
    IR_Data = 32'h01000010;
    drain(5);
    do_reset("ld_abort");
    run(32'h09000065, 1'b0, "ldi_after_rst");

    run(32'hD8000000, 1'b0, "halt");
    do_reset("halt");
    push("post_halt.F0", PCS | MAR);
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardware control unit for the datapath. It generates, cycle by cycle, the enable and select signals that fetch an instruction, decode the IR opcode and execute it, so the datapath runs without a bench driving its control pins. It sits beside `datapath` and consumes its `IR_Data` and `con_output`. It drives every datapath control input except `manual` debug paths, which it still owns: `manual_R15_enable`.

## Interface
- `RESET_PC_WAIT`, default 0: number of idle cycles after reset deassertion before the first fetch.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `IR_Data`  in  32  instruction register contents. Opcode is `IR[31:27]`, Ra is `[26:23]`, Rb is `[22:19]`, C is `[18:0]`.
- `con_output`  in  1  branch-condition flip-flop output from the datapath.
- `PC_enable`, `PC_increment_enable`, `IR_enable`, `Y_enable`, `Z_enable`, `MAR_enable`, `MDR_enable`, `r_enable`, `con_enable`, `manual_R15_enable`  out  1 each  register load enables.
- `read`, `write`  out  1 each  memory read/MDR-mux select and memory write strobe.
- `Gra`, `Grb`, `ba_select`  out  1 each  register-field select/encode controls.
- `PC_select`, `Z_LO_select`, `MDR_select`, `c_select`, `r_select`  out  1 each  bus-source selects.
- `alu_instruction`  out  5  ALU opcode.
- `halted`  out  1  high while in HALT.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode.

## Operation
- Outputs are Moore outputs, decoded from the state register. All outputs are 0 in any state not listed below.
- Fetch states:
  - F0: `PC_select`, `MAR_enable`.
  - F1: `PC_increment_enable`, `read`, `MDR_enable`.
  - F2: `MDR_select`, `IR_enable`.
- From F2 the FSM goes to T3. `IR_Data` is valid from T3 onward.
- `ldi` (00001):
  - T3: `Grb`, `ba_select`, `Y_enable`.
  - T4: `c_select`, `Z_enable`, `alu_instruction`=opcode.
  - T5: `Z_LO_select`, `Gra`, `r_enable`.
- `ld` (00000): T3 and T4 as `ldi`, then:
  - T5: `Z_LO_select`, `MAR_enable`.
  - T6: `read`, `MDR_enable`.
  - T7: `MDR_select`, `Gra`, `r_enable`.
- `st` (00010): T3 to T5 as `ld`, then:
  - T6: `Gra`, `r_select`, `MDR_enable` (with `read`=0).
  - T7: `write`.
- `addi`/`andi`/`ori` (01100/01101/01110): same as `ldi`, but T3 drives `Grb`, `r_select`, `Y_enable` (no `ba_select`).
- `neg`/`not` (10001/10010):
  - T3: `Grb`, `r_select`, `Z_enable`, `alu_instruction`=opcode.
  - T4: `Z_LO_select`, `Gra`, `r_enable`.
- `br` (10011):
  - T3: `Gra`, `r_select`, `con_enable`.
  - T4: `PC_select`, `Y_enable`.
  - T5: `c_select`, `Z_enable`, `alu_instruction`=ALU_ADD (00011).
  - T6: if `con_output`=1, drive `Z_LO_select`, `PC_enable`; otherwise drive nothing.
- `jal` (10100):
  - T3: `manual_R15_enable`, `PC_select`.
  - T4: `Gra`, `r_select`, `PC_enable`.
- `jr` (10101): T3: `Gra`, `r_select`, `PC_enable`.
- `nop` (11010): T3 drives nothing.
- `halt` (11011): T3 goes to HALT. HALT holds `halted`=1 and loops there until reset.
- Any other opcode: T3 pulses `illegal` and behaves as `nop`.
- Three-register ALU ops are unsupported because the datapath exposes only `Gra`/`Grb`.
- The last T-state of every instruction returns to F0.

## Timing
- Reset (asserted at any time, including mid-instruction): state goes to WAIT, or to F0 if `RESET_PC_WAIT`=0. All outputs drop to 0 immediately, without waiting for a clock edge.
- WAIT counts `RESET_PC_WAIT` cycles, then goes to F0.
- One state per clock, with no stalls. Instruction latency from F0 entry:
  - `jr`, `nop`: 4 cycles.
  - `neg`, `not`, `jal`: 5 cycles.
  - `ldi`, `addi`/`andi`/`ori`: 6 cycles.
  - `br`: 7 cycles.
  - `ld`, `st`: 8 cycles.
- `con_output` is sampled during T6 of `br`. It is stable there because it was loaded at the end of T3.
- Decoding uses live `IR_Data`. IR loads only in F2, so `IR_Data` is constant through T3 to T7.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - opcode constants;
  - the state enum: WAIT, F0, F1, F2, T3 to T7, HALT;
  - `ALU_ADD`;
  - the instruction-class enum.
- Sub-module `instr_decoder` is combinational. It maps the opcode to an instruction class and a legal flag.
- The FSM and output decode live in `control_sequencer`.

## Test plan
- Reset mid-`ld` at T5 → all outputs 0 asynchronously. After release, F0 (`PC_select`=`MAR_enable`=1) on the first edge.
- `IR`=0x09000065 (`ldi` R2, 0x65) → T3 `Grb`/`ba_select`/`Y_enable`; T4 `c_select`, `alu_instruction`=00001; T5 `r_enable`. Then F0 six cycles after the first F0.
- `IR`=0xA1000000 (`jal` R2) → T3 `manual_R15_enable`+`PC_select`; T4 `Gra`+`r_select`+`PC_enable`; F0 on the next cycle.
- `IR`=0x99800005 (`br` R3) with `con_output`=1 → `PC_enable` in T6. With `con_output`=0 → all outputs 0 in T6, then F0.
- `IR`=0x18000000 (opcode 00011) → `illegal` high for exactly one cycle in T3, then F0.
- `IR`=0xD8000000 (`halt`) → `halted`=1 held for 20 or more cycles with every enable 0. Reset clears `halted`.
